hdb3_tx_sched: RTL and testbench

HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

---
 rtl/hdb3_tx_sched.sv | 88 ++++++++
 tb/tb_hdb3_tx_sched.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hdb3_tx_sched.sv
// hdb3_tx_sched: frames payload bytes behind a sync byte as an MSB-first NRZ stream for an HDB3 encoder
// Ports: clk/rst (sync, active-high); start, abort, frame_len (0 = 256) control a frame;
// byte_in/byte_valid/byte_ready form the payload handshake; data_m is the serial bit;
// busy, frame_done, underrun_cnt report status.
module hdb3_tx_sched #(
  parameter logic [7:0] SYNC_WORD = 8'hE4,
  parameter logic [7:0] FILL_BYTE = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data_m,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] underrun_cnt
);
  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;
  state_t     state_q;
  logic [7:0] sr_q;
  logic [2:0] bit_q;
  logic [8:0] left_q;
  logic       data_m_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] ucnt_q;
  logic [7:0] load_byte;
  assign byte_ready   = (state_q != IDLE) && (bit_q == 3'd7) && (left_q != 9'd0) && !abort;
  assign load_byte    = byte_valid ? byte_in : FILL_BYTE;
  assign data_m       = data_m_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign underrun_cnt = ucnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= 8'd0;
      bit_q    <= 3'd0;
      left_q   <= 9'd0;
      data_m_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ucnt_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        sr_q     <= 8'd0;
        bit_q    <= 3'd0;
        left_q   <= 9'd0;
        data_m_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (state_q == IDLE) begin
        if (start) begin
          state_q  <= SYNC;
          sr_q     <= SYNC_WORD;
          data_m_q <= SYNC_WORD[7];
          bit_q    <= 3'd0;
          left_q   <= {frame_len == 8'd0, frame_len};
          busy_q   <= 1'b1;
        end
      end else if (bit_q != 3'd7) begin
        // data_m always mirrors sr_q[7], so the next bit out is sr_q[6]
        sr_q     <= {sr_q[6:0], 1'b0};
        data_m_q <= sr_q[6];
        bit_q    <= bit_q + 3'd1;
      end else if (left_q != 9'd0) begin
        state_q  <= PAYLOAD;
        sr_q     <= load_byte;
        data_m_q <= load_byte[7];
        bit_q    <= 3'd0;
        left_q   <= left_q - 9'd1;
        if (!byte_valid && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
      end else begin
        state_q  <= IDLE;
        sr_q     <= 8'd0;
        bit_q    <= 3'd0;
        data_m_q <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hdb3_tx_sched.sv
// tb_hdb3_tx_sched: directed scoreboard bench for hdb3_tx_sched
module tb_hdb3_tx_sched;
  localparam logic [7:0] SYNC = 8'hE4;
  localparam logic [7:0] FILL = 8'h55;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       data_m;
  logic       busy;
  logic       frame_done;
  logic [7:0] underrun_cnt;
  int         errors = 0;
  int         checks = 0;
  int         exp_under = 0;
  logic       exp_q[$];
  logic [7:0] src[$];
  hdb3_tx_sched #(.SYNC_WORD(SYNC), .FILL_BYTE(FILL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .data_m(data_m), .busy(busy), .frame_done(frame_done), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data_m"}, data_m, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ready"}, byte_ready, 0);
  endtask
  task automatic run_frame(input int n, input int drop, input bit all_inv, input int kill_at, input bit kill_rst, input bit poke);
    int eff = (n == 0) ? 256 : n;
    int cyc = 0;
    int k = 0;
    logic [7:0] b;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    frame_len = n[7:0];
    for (int i = 7; i >= 0; i--) exp_q.push_back(SYNC[i]);
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b0;
      if (!busy) begin
        chk("frame_done", frame_done, 1);
        chk("busy_cycles", cyc, 8 * (eff + 1));
        chk("bytes_taken", k, eff);
        chk("queue_left", exp_q.size(), 0);
        chk("underrun_cnt", underrun_cnt, exp_under);
        @(negedge clk);
        chk("done_pulse_width", frame_done, 0);
        return;
      end
      cyc++;
      if (exp_q.size() == 0) chk("queue_empty", 1, 0);
      else chk("data_m", data_m, exp_q.pop_front());
      start = poke && (cyc == 5 || cyc == 20);
      if (poke && cyc == 5) frame_len = 8'd7;
      if (cyc == kill_at) begin
        byte_valid = 1'b1;
        byte_in = 8'hC3;
        if (kill_rst) rst = 1'b1;
        else abort = 1'b1;
        #1;
        if (!kill_rst) chk("abort_ready", byte_ready, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        idle_chk(kill_rst ? "rst_kill" : "abort_kill");
        if (kill_rst) exp_under = 0;
        chk("kill_underrun", underrun_cnt, exp_under);
        rst = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        idle_chk(kill_rst ? "rst_after" : "abort_after");
        return;
      end
      if (byte_ready) begin
        b = (src.size() != 0) ? src.pop_front() : 8'($urandom);
        byte_in = b;
        byte_valid = !(all_inv || k == drop);
        if (!byte_valid) begin
          b = FILL;
          exp_under = (exp_under == 255) ? 255 : exp_under + 1;
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        k++;
      end
    end
    chk("timeout", 1, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset_underrun", underrun_cnt, 0);
    rst = 1'b0;
    src = '{8'hA5, 8'h3C};
    run_frame(2, -1, 0, 0, 0, 0);
    src = '{8'h11, 8'h22, 8'h33};
    run_frame(3, 1, 0, 0, 0, 0);
    run_frame(0, -1, 0, 0, 0, 0);
    run_frame(4, -1, 0, 12, 0, 0);
    run_frame(4, -1, 0, 16, 0, 0);
    src = '{8'h96, 8'h0F};
    run_frame(2, -1, 0, 0, 0, 0);
    run_frame(0, -1, 1, 0, 0, 0);
    run_frame(50, -1, 1, 0, 0, 0);
    chk("underrun_sat", underrun_cnt, 255);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    idle_chk("start_abort");
    run_frame(3, -1, 0, 0, 0, 1);
    run_frame(2, -1, 0, 3, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
